// File: rtl/seq_restoring_divider_if.sv
// Operand/result bundle for the sequential restoring divider.
// Latency: none; this is wiring only.
// Backpressure: none. Requests are taken only while busy is low.
interface seq_restoring_divider_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   // Requester side: issues operands and observes results.
   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   // Divider side.
   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/seq_restoring_divider.sv
// Unsigned restoring divider that produces one quotient bit per clock.
// Latency: WIDTH+1 edges from an accepted start to done, or 1 edge when the divisor is zero.
// Backpressure: start is ignored while busy is high; results hold until the next completion.
module seq_restoring_divider #(
   parameter int WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   seq_restoring_divider_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;

   logic [WIDTH-1:0] r_divisor;
   logic [WIDTH-1:0] r_prem;      // partial remainder
   logic [WIDTH-1:0] r_qsh;       // dividend bits shift out, quotient bits shift in
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_quotient;
   logic [WIDTH-1:0] r_remainder;
   logic             r_dbz;

   logic [WIDTH:0]   w_shift;
   logic [WIDTH:0]   w_trial;
   logic [WIDTH-1:0] w_prem_nxt;
   logic [WIDTH-1:0] w_qsh_nxt;
   logic             w_last;
   logic             w_busy;
   logic             w_done;

   // One restoring step: bring down the next dividend bit and try to subtract.
   // The extra top bit of the trial is the borrow; a set borrow means restore.
   assign w_shift    = {r_prem, r_qsh[WIDTH-1]};
   assign w_trial    = w_shift - {1'b0, r_divisor};
   assign w_prem_nxt = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
   assign w_qsh_nxt  = {r_qsh[WIDTH-2:0], ~w_trial[WIDTH]};
   assign w_last     = (r_cnt == CW'(1));

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic: a zero divisor skips straight to completion.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_state_nxt = (bus.divisor == '0) ? DONE : CALC;
            end
         end
         CALC: begin
            if (w_last) begin
               w_state_nxt = DONE;
            end
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Status outputs decoded from the state alone.
   always_comb begin
      w_busy = 1'b0;
      w_done = 1'b0;
      case (r_state)
         IDLE: begin
            w_busy = 1'b0;
            w_done = 1'b0;
         end
         CALC: begin
            w_busy = 1'b1;
            w_done = 1'b0;
         end
         DONE: begin
            w_busy = 1'b1;
            w_done = 1'b1;
         end
         default: begin
            w_busy = 1'b0;
            w_done = 1'b0;
         end
      endcase
   end

   // Datapath: capture operands, iterate, and publish results only on entry to DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_divisor   <= '0;
         r_prem      <= '0;
         r_qsh       <= '0;
         r_cnt       <= '0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_dbz       <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_divisor <= bus.divisor;
                  if (bus.divisor == '0) begin
                     r_quotient  <= '1;
                     r_remainder <= bus.dividend;
                     r_dbz       <= 1'b1;
                  end else begin
                     r_prem <= '0;
                     r_qsh  <= bus.dividend;
                     r_cnt  <= CW'(WIDTH);
                  end
               end
            end
            CALC: begin
               r_prem <= w_prem_nxt;
               r_qsh  <= w_qsh_nxt;
               r_cnt  <= r_cnt - CW'(1);
               if (w_last) begin
                  r_quotient  <= w_qsh_nxt;
                  r_remainder <= w_prem_nxt;
                  r_dbz       <= 1'b0;
               end
            end
            default: begin
               r_prem <= r_prem;
            end
         endcase
      end
   end

   assign bus.busy        = w_busy;
   assign bus.done        = w_done;
   assign bus.quotient    = r_quotient;
   assign bus.remainder   = r_remainder;
   assign bus.div_by_zero = r_dbz;
endmodule
